// File: rtl/pixel_row_packer.sv
// -----------------------------------------------------------------------------
// pixel_row_packer
//
// Binarizes a raster stream of 8-bit grayscale pixels against THRESH. Each row
// of 32 pixels is packed into a 32-bit word and written to the 32x32 image
// buffer (one write per row). The block raises frame_done after all 32 rows
// are written.
//
// Optional feature: define PACKER_BBOX_EN to track the bounding box of ink
// pixels. When it is not defined, the bbox outputs are tied to constants.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle pulse that begins or restarts a frame capture
//   pix_vld, pix   : pixel stream input (raster order, row 0 col 0 first)
//   pix_rdy        : pixel is accepted when pix_vld && pix_rdy
//   we/waddr/wdata : buffer write port (one pulse per row, col 0 in bit 31)
//   busy           : capture in progress (CAPT or FLUSH)
//   frame_done     : level, all 32 rows written, held until next start
//   bbox_*         : ink bounding box (rows/cols) and its valid flag
// -----------------------------------------------------------------------------
module pixel_row_packer #(
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pix_vld,
    input  logic [7:0]  pix,
    output logic        pix_rdy,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        frame_done,
    output logic [4:0]  bbox_rmin,
    output logic [4:0]  bbox_rmax,
    output logic [4:0]  bbox_cmin,
    output logic [4:0]  bbox_cmax,
    output logic        bbox_vld
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  col_q;
    logic [4:0]  row_q;
    // Only 31 bits of history are needed: the 32nd bit is the pixel being
    // accepted in the cycle the row completes.
    logic [30:0] sreg_q;
    logic        we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;

    logic        ink;
    logic        accept;
    logic        row_end;
    logic        clear;
    logic [31:0] word_d;

    assign ink     = (pix >= THRESH);
    assign accept  = pix_vld && pix_rdy;
    assign row_end = accept && (col_q == 5'd31);
    // start restarts capture from every state except FLUSH, where it is ignored.
    assign clear   = start && (state_q != ST_FLUSH);
    assign word_d  = {sreg_q, ink};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of process order.
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CAPT;
            ST_CAPT: begin
                if (start) begin
                    state_d = ST_CAPT;
                end else if (row_end && (row_q == 5'd31)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_CAPT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // A start pulse in CAPT aborts the frame, so the pixel offered in that
        // cycle is refused rather than silently dropped.
        pix_rdy    = (state_q == ST_CAPT) && !start;
        busy       = (state_q == ST_CAPT) || (state_q == ST_FLUSH);
        frame_done = (state_q == ST_DONE);
    end

    // -------------------------------------------------------------------------
    // Datapath: column/row counters, shift register, buffer write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            sreg_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (clear) begin
                col_q  <= '0;
                row_q  <= '0;
                sreg_q <= '0;
            end else if (accept) begin
                sreg_q <= word_d[30:0];
                col_q  <= col_q + 5'd1;
                if (col_q == 5'd31) begin
                    we_q    <= 1'b1;
                    waddr_q <= row_q;
                    wdata_q <= word_d;
                    row_q   <= row_q + 5'd1;
                end
            end
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    // -------------------------------------------------------------------------
    // Ink bounding box
    // -------------------------------------------------------------------------
`ifdef PACKER_BBOX_EN
    logic [4:0] rmin_q, rmax_q, cmin_q, cmax_q;
    logic       bvld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmin_q <= 5'd31;
            rmax_q <= 5'd0;
            cmin_q <= 5'd31;
            cmax_q <= 5'd0;
            bvld_q <= 1'b0;
        end else if (clear) begin
            rmin_q <= 5'd31;
            rmax_q <= 5'd0;
            cmin_q <= 5'd31;
            cmax_q <= 5'd0;
            bvld_q <= 1'b0;
        end else if (accept && ink) begin
            if (row_q < rmin_q) rmin_q <= row_q;
            if (row_q > rmax_q) rmax_q <= row_q;
            if (col_q < cmin_q) cmin_q <= col_q;
            if (col_q > cmax_q) cmax_q <= col_q;
            bvld_q <= 1'b1;
        end
    end

    assign bbox_rmin = rmin_q;
    assign bbox_rmax = rmax_q;
    assign bbox_cmin = cmin_q;
    assign bbox_cmax = cmax_q;
    assign bbox_vld  = bvld_q;
`else
    assign bbox_rmin = 5'd0;
    assign bbox_rmax = 5'd31;
    assign bbox_cmin = 5'd0;
    assign bbox_cmax = 5'd31;
    assign bbox_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_row_packer.sv
// -----------------------------------------------------------------------------
// tb_pixel_row_packer
//
// Directed testbench for pixel_row_packer. Inputs are driven on the falling
// edge; buffer writes are captured on the falling edge, where the image buffer
// samples them, and compared against a row model built from the stimulus image.
// -----------------------------------------------------------------------------
module tb_pixel_row_packer;

`ifdef PACKER_BBOX_EN
    localparam bit BBOX = 1'b1;
`else
    localparam bit BBOX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pix_vld = 1'b0;
    logic [7:0]  pix = 8'd0;
    logic        pix_rdy;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        frame_done;
    logic [4:0]  bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax;
    logic        bbox_vld;

    pixel_row_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_vld    (pix_vld),
        .pix        (pix),
        .pix_rdy    (pix_rdy),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .bbox_rmin  (bbox_rmin),
        .bbox_rmax  (bbox_rmax),
        .bbox_cmin  (bbox_cmin),
        .bbox_cmax  (bbox_cmax),
        .bbox_vld   (bbox_vld)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  img [1024];
    logic [31:0] exp_row [32];
    logic [36:0] wq [$];

    // Capture every buffer write where the buffer itself samples it.
    always @(negedge clk) begin
        if (we === 1'b1) wq.push_back({waddr, wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Expected packed rows: column 0 in bit 31, ink when pixel >= 128.
    task automatic build_model();
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                exp_row[r][31-c] = (img[r*32+c] >= 8'd128);
            end
        end
    endtask

    task automatic fill_img(input logic [7:0] v);
        for (int i = 0; i < 1024; i++) img[i] = v;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 1024; i++) img[i] = 8'((i * 37) + ((i >> 5) * 11));
    endtask

    task automatic check_bbox(input string tag, input logic [4:0] rmin, input logic [4:0] rmax,
                              input logic [4:0] cmin, input logic [4:0] cmax, input logic vld);
        check({tag, "_rmin"}, 32'(bbox_rmin), 32'(rmin));
        check({tag, "_rmax"}, 32'(bbox_rmax), 32'(rmax));
        check({tag, "_cmin"}, 32'(bbox_cmin), 32'(cmin));
        check({tag, "_cmax"}, 32'(bbox_cmax), 32'(cmax));
        check({tag, "_vld"},  32'(bbox_vld),  32'(vld));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   32'(pix_rdy),    32'd0);
        check({tag, "_we"},    32'(we),         32'd0);
        check({tag, "_waddr"}, 32'(waddr),      32'd0);
        check({tag, "_wdata"}, wdata,           32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(frame_done), 32'd0);
        if (BBOX) check_bbox(tag, 5'd31, 5'd0, 5'd31, 5'd0, 1'b0);
        else      check_bbox(tag, 5'd0, 5'd31, 5'd0, 5'd31, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        pix_vld = 1'b0;
        start   = 1'b1;
        #1 check("start_rdy", 32'(pix_rdy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("capt_rdy",  32'(pix_rdy),    32'd1);
        check("capt_busy", 32'(busy),       32'd1);
        check("capt_done", 32'(frame_done), 32'd0);
    endtask

    // Offer img[0..n-1]; gap_pct is the chance of an idle pix_vld cycle.
    task automatic drive_frame(input int n, input int gap_pct, input bit chk_done);
        int idx = 0;
        int budget = 0;
        while (idx < n && budget < 20000) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < gap_pct) begin
                pix_vld = 1'b0;
            end else begin
                pix_vld = 1'b1;
                pix     = img[idx];
                #1;
                if (pix_rdy) idx++;
            end
            budget++;
        end
        if (idx < n) check("drive_timeout", 32'(idx), 32'(n));
        @(negedge clk);
        pix_vld = 1'b0;
        if (chk_done) begin
            #1;
            check("flush_we",    32'(we),         32'd1);
            check("flush_waddr", 32'(waddr),      32'd31);
            check("flush_busy",  32'(busy),       32'd1);
            check("flush_done",  32'(frame_done), 32'd0);
            @(negedge clk);
            #1;
            check("done_level", 32'(frame_done), 32'd1);
            check("done_busy",  32'(busy),       32'd0);
        end
    endtask

    task automatic check_frame_writes(input string tag);
        logic [36:0] e;
        check({tag, "_nwrites"}, 32'(wq.size()), 32'd32);
        for (int i = 0; i < 32 && wq.size() > 0; i++) begin
            e = wq.pop_front();
            check($sformatf("%s_waddr[%0d]", tag, i), 32'(e[36:32]), 32'(i));
            check($sformatf("%s_wdata[%0d]", tag, i), e[31:0], exp_row[i]);
        end
        wq.delete();
    endtask

    initial begin
        logic [36:0] e;

        // Reset state
        repeat (3) @(negedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("idle_rdy", 32'(pix_rdy), 32'd0);

        // All-ink frame, continuous stream
        fill_img(8'd200);
        build_model();
        pulse_start();
        drive_frame(1024, 0, 1'b1);
        check_frame_writes("allink");
        check_bbox("allink_bbox", BBOX ? 5'd0 : 5'd0, 5'd31, 5'd0, 5'd31, BBOX);

        // DONE refuses pixels and writes nothing
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pix_vld = 1'b1;
            pix     = 8'd200;
            #1;
            check("done_rdy",  32'(pix_rdy),    32'd0);
            check("done_hold", 32'(frame_done), 32'd1);
        end
        pix_vld = 1'b0;
        @(negedge clk);
        check("done_nowrite", 32'(wq.size()), 32'd0);

        // Threshold edge: row 5 alternating 128/127
        fill_img(8'd0);
        for (int c = 0; c < 32; c++) img[5*32+c] = (c % 2 == 0) ? 8'd128 : 8'd127;
        build_model();
        check("model_row5", exp_row[5], 32'hAAAA_AAAA);
        pulse_start();
        drive_frame(1024, 0, 1'b1);
        check_frame_writes("thresh");

        // Mixed pattern: gap-free, then with ~50% idle cycles
        fill_pattern();
        build_model();
        pulse_start();
        drive_frame(1024, 0, 1'b1);
        check_frame_writes("pat_nogap");
        pulse_start();
        drive_frame(1024, 50, 1'b1);
        check_frame_writes("pat_gap");

        // Abort after 40 pixels: only row 0 of the partial frame is written
        fill_img(8'd200);
        pulse_start();
        drive_frame(40, 0, 1'b0);
        pulse_start();
        fill_pattern();
        build_model();
        drive_frame(1024, 0, 1'b1);
        check("abort_nwrites", 32'(wq.size()), 32'd33);
        if (wq.size() > 0) begin
            e = wq.pop_front();
            check("abort_partial_waddr", 32'(e[36:32]), 32'd0);
            check("abort_partial_wdata", e[31:0], 32'hFFFF_FFFF);
        end
        check_frame_writes("abort");

        // Bounding box: ink at (3,7) and (20,25)
        fill_img(8'd0);
        img[3*32+7]   = 8'd255;
        img[20*32+25] = 8'd255;
        build_model();
        pulse_start();
        drive_frame(1024, 0, 1'b1);
        check_frame_writes("bbox");
        if (BBOX) check_bbox("bbox", 5'd3, 5'd20, 5'd7, 5'd25, 1'b1);
        else      check_bbox("bbox", 5'd0, 5'd31, 5'd0, 5'd31, 1'b0);

        // Reset during row 10, then a clean frame from row 0
        fill_pattern();
        build_model();
        pulse_start();
        if (BBOX) check_bbox("restart_bbox", 5'd31, 5'd0, 5'd31, 5'd0, 1'b0);
        drive_frame(10*32 + 5, 0, 1'b0);
        check("prerst_nwrites", 32'(wq.size()), 32'd10);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        wq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        drive_frame(1024, 0, 1'b1);
        check_frame_writes("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
